// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, serial line levels
// and an even-parity helper. Used by both the transmit and receive paths.
package uart_pkg;

    // Transmitter frame states. PARITY is only reachable when the parity
    // bit is compiled in (UART_TX_PARITY_EN).
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Serial line levels for the idle line, start bit and stop bit.
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    // Even parity over up to eight data bits; narrower words are zero-extended
    // by the caller, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Programmable bit timer. Counts 1..rollover_val while enabled and wraps
// back to 1. A clear restarts the period at 1 so that the cycle following
// the clear is the first cycle of the new period. rollover_flag is high for
// the cycle in which the count equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic                    rollover_flag_q;
    logic                    rollover_flag_d;

    // Next count: clear restarts at 1, enable increments with wrap to 1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CNT_ONE;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = CNT_ONE;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
        rollover_flag_d = (count_d == rollover_val);
    end

    // Counter and flag registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q         <= '0;
            rollover_flag_q <= 1'b0;
        end else begin
            count_q         <= count_d;
            rollover_flag_q <= rollover_flag_d;
        end
    end

    assign rollover_flag = rollover_flag_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter control path. Serialises one DATA_BITS-wide word per
// accepted request as: start bit, data LSB first, optional even parity bit,
// one stop bit. Each bit lasts CLKS_PER_BIT clocks, timed by flex_counter.
// Optional feature macro: UART_TX_PARITY_EN inserts the even parity bit.
// All outputs are registered; the asynchronous reset forces the line high
// immediately and abandons any frame in progress.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [15:0] BIT_CLKS = 16'(CLKS_PER_BIT);
    localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_t            state_q;
    tx_state_t            state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [2:0]           bit_idx_q;
    logic [2:0]           bit_idx_d;
    logic                 serial_out_q;
    logic                 serial_out_d;
    logic                 tx_busy_q;
    logic                 tx_busy_d;
    logic                 tx_done_q;
    logic                 tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
    logic                 parity_d;
`endif

    logic                 accept_s;
    logic                 bit_end_s;

    // Bit timer: runs while a frame is in progress and restarts on accept.
    flex_counter #(
        .NUM_CNT_BITS (16)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (accept_s),
        .count_enable  (tx_busy_q),
        .rollover_val  (BIT_CLKS),
        .rollover_flag (bit_end_s)
    );

    // Frame sequencing: next state, shift register, bit index and the
    // next values of the registered line/status outputs.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        serial_out_d = serial_out_q;
        tx_busy_d    = tx_busy_q;
        tx_done_d    = 1'b0;
        accept_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                serial_out_d = UART_IDLE_LVL;
                tx_busy_d    = 1'b0;
                if (tx_start) begin
                    // Accepting edge: the start bit goes out from this edge.
                    accept_s     = 1'b1;
                    shift_d      = tx_data;
                    bit_idx_d    = 3'd0;
                    state_d      = START;
                    serial_out_d = UART_START_LVL;
                    tx_busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d     = even_parity(8'(tx_data));
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d      = DATA;
                    bit_idx_d    = 3'd0;
                    serial_out_d = shift_q[0];
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d      = PARITY;
                        serial_out_d = parity_q;
`else
                        state_d      = STOP;
                        serial_out_d = UART_STOP_LVL;
`endif
                    end else begin
                        // The next data bit is the one about to shift into bit 0.
                        bit_idx_d    = bit_idx_q + 3'd1;
                        serial_out_d = shift_q[1];
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_d      = STOP;
                    serial_out_d = UART_STOP_LVL;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    state_d      = IDLE;
                    serial_out_d = UART_IDLE_LVL;
                    tx_busy_d    = 1'b0;
                    tx_done_d    = 1'b1;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                // Unreachable encodings recover to a quiet idle line.
                state_d      = IDLE;
                serial_out_d = UART_IDLE_LVL;
                tx_busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns to a quiet, idle line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= 3'd0;
            serial_out_q <= UART_IDLE_LVL;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            serial_out_q <= serial_out_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign serial_out = serial_out_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. The expected line level for every
// cycle of a frame is derived from the frame layout (bit position = cycle /
// CLKS_PER_BIT) rather than from any state machine.
module tb_uart_tx_ctrl;

    localparam int CLKS  = 10;
    localparam int DBITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DBITS + 3;
`else
    localparam int NBITS = DBITS + 2;
`endif
    localparam int FRAME = NBITS * CLKS;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             tx_start;
    logic [DBITS-1:0] tx_data;
    logic             serial_out;
    logic             tx_busy;
    logic             tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (DBITS)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after the accepting edge.
    function automatic logic exp_line(input logic [DBITS-1:0] d, input int k);
        int b;
        b = k / CLKS;
        if (b == 0) return 1'b0;
        if (b <= DBITS) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == DBITS + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Request a frame, check every cycle of it, and check the done cycle.
    // hold keeps tx_start high throughout; inject_at raises a competing
    // request in that cycle. tx_data is scrambled during the frame.
    task automatic run_frame(input logic [DBITS-1:0] data, input bit hold,
                             input int inject_at, input logic [DBITS-1:0] inj);
        tx_data  = data;
        tx_start = 1'b1;
        tick();
        for (int k = 0; k < FRAME; k++) begin
            chk($sformatf("busy@%0d", k), tx_busy, 1'b1);
            chk($sformatf("line@%0d d=%h", k, data), serial_out, exp_line(data, k));
            chk($sformatf("done@%0d", k), tx_done, 1'b0);
            tx_start = hold;
            tx_data  = DBITS'($urandom);
            if (k == inject_at) begin
                tx_start = 1'b1;
                tx_data  = inj;
            end
            tick();
        end
        chk("done_pulse", tx_done, 1'b1);
        chk("done_busy", tx_busy, 1'b0);
        chk("done_line", serial_out, 1'b1);
    endtask

    // Quiet cycles: line high, not busy, no done pulse.
    task automatic idle(input int n);
        tx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_busy", tx_busy, 1'b0);
            chk("idle_line", serial_out, 1'b1);
            chk("idle_done", tx_done, 1'b0);
        end
    endtask

    initial begin
        logic [DBITS-1:0] d;
        bit               h;

        // Reset state.
        n_rst    = 1'b1;
        tx_start = 1'b0;
        tx_data  = '0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_line", serial_out, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        tick();
        tick();
        chk("rst_hold_line", serial_out, 1'b1);
        n_rst = 1'b1;
        idle(3);

        // Single frame.
        run_frame(8'hA5, 1'b0, -1, 8'h00);
        idle(3);

        // Request while busy is ignored: no second frame follows.
        run_frame(8'hA5, 1'b0, 40, 8'h3C);
        idle(FRAME + 5);

        // Back-to-back with tx_start held high.
        run_frame(8'h00, 1'b1, -1, 8'h00);
        run_frame(8'hFF, 1'b1, -1, 8'h00);
        idle(3);

        // Reset mid-frame, then request in the release cycle.
        tx_data  = 8'h96;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 0; k < 35; k++) begin
            chk($sformatf("pre_abort_line@%0d", k), serial_out, exp_line(8'h96, k));
            tick();
        end
        n_rst = 1'b0;
        #1;
        chk("abort_line", serial_out, 1'b1);
        chk("abort_busy", tx_busy, 1'b0);
        chk("abort_done", tx_done, 1'b0);
        tick();
        tick();
        chk("abort_hold_line", serial_out, 1'b1);
        n_rst = 1'b1;
        run_frame(8'h5A, 1'b0, -1, 8'h00);
        idle(2);

        // Randomised frames, gaps, holds and competing requests.
        for (int r = 0; r < 6; r++) begin
            d = DBITS'($urandom);
            h = 1'($urandom_range(0, 1));
            run_frame(d, h, int'($urandom_range(0, FRAME - 1)), DBITS'($urandom));
            idle(int'($urandom_range(0, 3)));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
